// File: rtl/snitch_dma_perf_monitor_if.sv
// Snooped DMA AXI handshake bundle observed by the performance monitor.
// The bus driver uses the master modport; the monitor only listens through the slave modport.
interface snitch_dma_perf_monitor_if #(
    parameter int unsigned DataWidth = 512
);
    logic                   aw_valid;
    logic                   aw_ready;
    logic [7:0]             aw_len;
    logic [2:0]             aw_size;
    logic                   ar_valid;
    logic                   ar_ready;
    logic [7:0]             ar_len;
    logic [2:0]             ar_size;
    logic                   w_valid;
    logic                   w_ready;
    logic                   w_last;
    logic [DataWidth/8-1:0] w_strb;
    logic                   r_valid;
    logic                   r_ready;
    logic                   r_last;
    logic                   b_valid;
    logic                   b_ready;

    modport master (
        output aw_valid, aw_ready, aw_len, aw_size,
        output ar_valid, ar_ready, ar_len, ar_size,
        output w_valid, w_ready, w_last, w_strb,
        output r_valid, r_ready, r_last,
        output b_valid, b_ready
    );

    modport slave (
        input aw_valid, aw_ready, aw_len, aw_size,
        input ar_valid, ar_ready, ar_len, ar_size,
        input w_valid, w_ready, w_last, w_strb,
        input r_valid, r_ready, r_last,
        input b_valid, b_ready
    );
endinterface

// File: rtl/snitch_dma_perf_monitor.sv
// DMA performance monitor: registers per-cycle AXI event pulses, burst attributes, bytes written,
// in-flight burst counters feeding a busy flag, and a sticky handshake-ordering error flag.
module snitch_dma_perf_monitor #(
    parameter int unsigned DataWidth      = 512,
    parameter int unsigned MaxOutstanding = 16,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned BytesW        = $clog2(StrbWidth) + 1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    snitch_dma_perf_monitor_if.slave      bus,
    input  logic                          backend_busy_i,
    output logic                          aw_stall_o,
    output logic                          ar_stall_o,
    output logic                          w_stall_o,
    output logic                          r_stall_o,
    output logic                          aw_done_o,
    output logic                          ar_done_o,
    output logic                          w_done_o,
    output logic                          r_done_o,
    output logic                          b_done_o,
    output logic                          dma_busy_o,
    output logic [7:0]                    aw_len_o,
    output logic [7:0]                    ar_len_o,
    output logic [2:0]                    aw_size_o,
    output logic [2:0]                    ar_size_o,
    output logic [BytesW-1:0]             num_bytes_written_o,
    output logic                          protocol_err_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    // One extra bit so w_os can hold a signed lead of W lasts over AWs.
    localparam int unsigned WOsW = CntW + 1;

    localparam logic [CntW-1:0]        CntMax = CntW'(MaxOutstanding);
    localparam logic signed [WOsW-1:0] WOsMax = WOsW'(MaxOutstanding);
    localparam logic signed [WOsW-1:0] WOsMin = -WOsMax;

    logic aw_hs, ar_hs, w_hs, r_hs, b_hs, r_last_hs, w_last_hs;

    assign aw_hs     = bus.aw_valid & bus.aw_ready;
    assign ar_hs     = bus.ar_valid & bus.ar_ready;
    assign w_hs      = bus.w_valid & bus.w_ready;
    assign r_hs      = bus.r_valid & bus.r_ready;
    assign b_hs      = bus.b_valid & bus.b_ready;
    assign r_last_hs = r_hs & bus.r_last;
    assign w_last_hs = w_hs & bus.w_last;

    logic [CntW-1:0]        wr_os_q, wr_os_d;
    logic [CntW-1:0]        rd_os_q, rd_os_d;
    logic signed [WOsW-1:0] w_os_q, w_os_d;
    logic                   err_q, err_d;
    logic [BytesW-1:0]      bytes_d;

    always_comb begin
        wr_os_d = wr_os_q;
        rd_os_d = rd_os_q;
        w_os_d  = w_os_q;
        err_d   = err_q;

        if (aw_hs && !b_hs) begin
            if (wr_os_q == CntMax) err_d = 1'b1;
            else                   wr_os_d = wr_os_q + 1'b1;
        end else if (b_hs && !aw_hs) begin
            if (wr_os_q == '0) err_d = 1'b1;
            else               wr_os_d = wr_os_q - 1'b1;
        end

        if (ar_hs && !r_last_hs) begin
            if (rd_os_q == CntMax) err_d = 1'b1;
            else                   rd_os_d = rd_os_q + 1'b1;
        end else if (r_last_hs && !ar_hs) begin
            if (rd_os_q == '0) err_d = 1'b1;
            else               rd_os_d = rd_os_q - 1'b1;
        end

        if (aw_hs && !w_last_hs) begin
            if (w_os_q == WOsMax) err_d = 1'b1;
            else                  w_os_d = w_os_q + WOsW'(1);
        end else if (w_last_hs && !aw_hs) begin
            if (w_os_q == WOsMin) err_d = 1'b1;
            else                  w_os_d = w_os_q - WOsW'(1);
        end
    end

    always_comb begin
        bytes_d = '0;
        if (w_hs) begin
            for (int i = 0; i < StrbWidth; i++) begin
                bytes_d = bytes_d + BytesW'(bus.w_strb[i]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_os_q             <= '0;
            rd_os_q             <= '0;
            w_os_q              <= '0;
            err_q               <= 1'b0;
            aw_stall_o          <= 1'b0;
            ar_stall_o          <= 1'b0;
            w_stall_o           <= 1'b0;
            r_stall_o           <= 1'b0;
            aw_done_o           <= 1'b0;
            ar_done_o           <= 1'b0;
            w_done_o            <= 1'b0;
            r_done_o            <= 1'b0;
            b_done_o            <= 1'b0;
            dma_busy_o          <= 1'b0;
            aw_len_o            <= '0;
            ar_len_o            <= '0;
            aw_size_o           <= '0;
            ar_size_o           <= '0;
            num_bytes_written_o <= '0;
        end else begin
            wr_os_q             <= wr_os_d;
            rd_os_q             <= rd_os_d;
            w_os_q              <= w_os_d;
            err_q               <= err_d;
            aw_stall_o          <= bus.aw_valid & ~bus.aw_ready;
            ar_stall_o          <= bus.ar_valid & ~bus.ar_ready;
            w_stall_o           <= bus.w_valid & ~bus.w_ready;
            r_stall_o           <= bus.r_valid & ~bus.r_ready;
            aw_done_o           <= aw_hs;
            ar_done_o           <= ar_hs;
            w_done_o            <= w_hs;
            r_done_o            <= r_hs;
            b_done_o            <= b_hs;
            // Busy looks at the post-update counters so a closing B/R drops it right away.
            dma_busy_o          <= (wr_os_d != '0) | (rd_os_d != '0) | backend_busy_i;
            aw_len_o            <= aw_hs ? bus.aw_len : 8'd0;
            aw_size_o           <= aw_hs ? bus.aw_size : 3'd0;
            ar_len_o            <= ar_hs ? bus.ar_len : 8'd0;
            ar_size_o           <= ar_hs ? bus.ar_size : 3'd0;
            num_bytes_written_o <= bytes_d;
        end
    end

    assign protocol_err_o = err_q;

endmodule

// File: tb/tb_snitch_dma_perf_monitor.sv
// Directed bench for snitch_dma_perf_monitor at DataWidth=512, MaxOutstanding=16.
module tb_snitch_dma_perf_monitor;

    localparam int unsigned DataWidth = 512;
    localparam int unsigned MaxOs     = 16;
    localparam int unsigned BytesW    = $clog2(DataWidth / 8) + 1;

    logic clk = 1'b0;
    logic rst;
    logic backend_busy;
    logic aw_stall, ar_stall, w_stall, r_stall;
    logic aw_done, ar_done, w_done, r_done, b_done, dma_busy, perr;
    logic [7:0] aw_len, ar_len;
    logic [2:0] aw_size, ar_size;
    logic [BytesW-1:0] nbytes;

    int n_vec = 0;
    int n_err = 0;

    snitch_dma_perf_monitor_if #(.DataWidth(DataWidth)) bus_if ();

    snitch_dma_perf_monitor #(
        .DataWidth      (DataWidth),
        .MaxOutstanding (MaxOs)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .bus                 (bus_if),
        .backend_busy_i      (backend_busy),
        .aw_stall_o          (aw_stall),
        .ar_stall_o          (ar_stall),
        .w_stall_o           (w_stall),
        .r_stall_o           (r_stall),
        .aw_done_o           (aw_done),
        .ar_done_o           (ar_done),
        .w_done_o            (w_done),
        .r_done_o            (r_done),
        .b_done_o            (b_done),
        .dma_busy_o          (dma_busy),
        .aw_len_o            (aw_len),
        .ar_len_o            (ar_len),
        .aw_size_o           (aw_size),
        .ar_size_o           (ar_size),
        .num_bytes_written_o (nbytes),
        .protocol_err_o      (perr)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Clear all snooped inputs (reset untouched).
    task automatic idle();
        bus_if.aw_valid = 0; bus_if.aw_ready = 0; bus_if.aw_len = 0; bus_if.aw_size = 0;
        bus_if.ar_valid = 0; bus_if.ar_ready = 0; bus_if.ar_len = 0; bus_if.ar_size = 0;
        bus_if.w_valid = 0; bus_if.w_ready = 0; bus_if.w_last = 0; bus_if.w_strb = '0;
        bus_if.r_valid = 0; bus_if.r_ready = 0; bus_if.r_last = 0;
        bus_if.b_valid = 0; bus_if.b_ready = 0;
        backend_busy = 0;
    endtask

    // Let the current inputs be sampled, then move 1 time unit past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic aw(input logic [7:0] len, input logic [2:0] size);
        bus_if.aw_valid = 1; bus_if.aw_ready = 1; bus_if.aw_len = len; bus_if.aw_size = size;
    endtask

    task automatic bresp();
        bus_if.b_valid = 1; bus_if.b_ready = 1;
    endtask

    initial begin
        logic [63:0] all_ones;
        all_ones = '1;
        idle();
        rst = 1;
        // Handshakes during reset must be ignored.
        aw(8'd5, 3'd2);
        bus_if.w_valid = 1; bus_if.w_ready = 1; bus_if.w_strb = all_ones;
        step();
        step();
        check_eq("rst_aw_done", aw_done, 0);
        check_eq("rst_w_done", w_done, 0);
        check_eq("rst_bytes", nbytes, 0);
        check_eq("rst_busy", dma_busy, 0);
        check_eq("rst_err", perr, 0);
        idle();
        rst = 0;
        step();
        check_eq("post_rst_busy", dma_busy, 0);

        // AW len=3 size=6, B ten cycles later.
        aw(8'd3, 3'd6);
        step();
        check_eq("aw_done", aw_done, 1);
        check_eq("aw_len", aw_len, 3);
        check_eq("aw_size", aw_size, 6);
        check_eq("aw_busy", dma_busy, 1);
        idle();
        for (int i = 0; i < 9; i++) step();
        check_eq("aw_len_idle", aw_len, 0);
        check_eq("aw_done_idle", aw_done, 0);
        check_eq("busy_hold", dma_busy, 1);
        bresp();
        step();
        check_eq("b_done", b_done, 1);
        check_eq("b_busy_drop", dma_busy, 0);
        idle();

        // W stalled 4 cycles, then accepted with strb=0x00FF and w_last ahead of any AW.
        bus_if.w_valid = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("w_stall", w_stall, 1);
            check_eq("w_done_stalled", w_done, 0);
        end
        bus_if.w_ready = 1; bus_if.w_strb = 64'h00FF; bus_if.w_last = 1;
        step();
        check_eq("w_stall_end", w_stall, 0);
        check_eq("w_done", w_done, 1);
        check_eq("bytes_8", nbytes, 8);
        check_eq("w_lead_no_err", perr, 0);
        bus_if.w_last = 0; bus_if.w_strb = all_ones;
        step();
        check_eq("bytes_64", nbytes, 64);
        bus_if.w_strb = 64'h8000_0000_0001_0010;
        step();
        check_eq("bytes_3", nbytes, 3);
        idle();

        // Stall pulses on the other channels and backend busy.
        bus_if.aw_valid = 1; bus_if.ar_valid = 1; bus_if.r_valid = 1;
        step();
        check_eq("aw_stall", aw_stall, 1);
        check_eq("ar_stall", ar_stall, 1);
        check_eq("r_stall", r_stall, 1);
        check_eq("stall_no_done", aw_done, 0);
        idle();
        backend_busy = 1;
        step();
        check_eq("backend_busy", dma_busy, 1);
        idle();

        // AR, then AR + R-last together (rd_os stays 1), then R-last closes it.
        bus_if.ar_valid = 1; bus_if.ar_ready = 1; bus_if.ar_len = 8'd7; bus_if.ar_size = 3'd4;
        step();
        check_eq("ar_done", ar_done, 1);
        check_eq("ar_len", ar_len, 7);
        check_eq("ar_size", ar_size, 4);
        bus_if.ar_len = 8'd1; bus_if.ar_size = 3'd3;
        bus_if.r_valid = 1; bus_if.r_ready = 1; bus_if.r_last = 1;
        step();
        check_eq("ar_r_ar_done", ar_done, 1);
        check_eq("ar_r_r_done", r_done, 1);
        check_eq("ar_r_busy", dma_busy, 1);
        bus_if.ar_valid = 0; bus_if.ar_ready = 0;
        step();
        check_eq("r_last_close", dma_busy, 0);
        check_eq("ar_len_zero", ar_len, 0);
        check_eq("no_err_yet", perr, 0);
        idle();

        // B with nothing outstanding is an error, held until reset.
        bresp();
        step();
        check_eq("b_underflow_err", perr, 1);
        idle();
        step();
        check_eq("err_sticky", perr, 1);
        check_eq("wr_os_zero", dma_busy, 0);
        rst = 1;
        step();
        check_eq("err_cleared", perr, 0);
        rst = 0;

        // 16 AWs fill wr_os, the 17th saturates; 16 Bs then drain it.
        for (int i = 0; i < 16; i++) begin
            aw(8'd0, 3'd0);
            step();
        end
        check_eq("os16_no_err", perr, 0);
        check_eq("os16_busy", dma_busy, 1);
        step();
        check_eq("os17_err", perr, 1);
        idle();
        for (int i = 0; i < 15; i++) begin
            bresp();
            step();
        end
        check_eq("drain15_busy", dma_busy, 1);
        step();
        check_eq("drain16_idle", dma_busy, 0);
        idle();

        // Reset mid-burst.
        aw(8'd15, 3'd5);
        step();
        step();
        bus_if.w_valid = 1; bus_if.w_ready = 1; bus_if.w_strb = all_ones;
        rst = 1;
        step();
        check_eq("mid_rst_aw_done", aw_done, 0);
        check_eq("mid_rst_aw_len", aw_len, 0);
        check_eq("mid_rst_bytes", nbytes, 0);
        check_eq("mid_rst_busy", dma_busy, 0);
        check_eq("mid_rst_err", perr, 0);
        idle();
        rst = 0;
        step();
        check_eq("after_rst_busy", dma_busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/snitch_dma_perf_monitor.md
SNITCH_DMA_PERF_MONITOR -- requirements
Module: snitch_dma_perf_monitor

Interface
REQ-001 SHALL have parameter DataWidth, default 512, DMA AXI data width in bits; legal values are powers of two from 32 to 1024.
REQ-002 SHALL have parameter MaxOutstanding, default 16, maximum in-flight bursts per direction; legal range is 1 to 255.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all logic rising-edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have ports aw_valid_i, aw_ready_i, ar_valid_i, ar_ready_i, w_valid_i, w_ready_i, w_last_i, r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i, all input, 1 bit each: snooped DMA AXI handshakes.
REQ-006 SHALL have ports aw_len_i and ar_len_i, input, 8 bits each: burst length minus 1.
REQ-007 SHALL have ports aw_size_i and ar_size_i, input, 3 bits each: log2 of beat bytes.
REQ-008 SHALL have port w_strb_i, input, DataWidth/8 bits: write strobe.
REQ-009 SHALL have port backend_busy_i, input, 1 bit: the DMA backend holds queued, unissued transfers.
REQ-010 SHALL have ports aw_stall_o, ar_stall_o, w_stall_o, r_stall_o, aw_done_o, ar_done_o, w_done_o, r_done_o, b_done_o, dma_busy_o, all output, 1 bit each: per-cycle event pulses.
REQ-011 SHALL have ports aw_len_o and ar_len_o, output, 8 bits each, and aw_size_o and ar_size_o, output, 3 bits each: burst attributes qualified by the matching *_done_o.
REQ-012 SHALL have port num_bytes_written_o, output, $clog2(DataWidth/8)+1 bits: bytes written this cycle.
REQ-013 SHALL have port protocol_err_o, output, 1 bit: sticky flag for a handshake-ordering violation.

Function
REQ-014 SHALL register every output exactly once, so each output reflects the bus cycle one clock earlier (latency 1).
REQ-015 SHALL set x_stall_o = x_valid_i & ~x_ready_i, for x in {aw, ar, w, r}.
REQ-016 SHALL set x_done_o = x_valid_i & x_ready_i, for x in {aw, ar, w, r, b}.
REQ-017 SHALL register aw_len_o/aw_size_o on an AW handshake and ar_len_o/ar_size_o on an AR handshake; otherwise each drives 0.
REQ-018 SHALL set num_bytes_written_o to popcount(w_strb_i) on a W handshake, else 0; the all-ones strobe yields DataWidth/8 with no truncation.
REQ-019 SHALL keep a write-outstanding counter wr_os: +1 on an AW handshake, -1 on a B handshake, unchanged when both occur in the same cycle.
REQ-020 SHALL keep a read-outstanding counter rd_os: +1 on an AR handshake, -1 on an R handshake with r_last_i, unchanged when both occur in the same cycle.
REQ-021 SHALL keep a write-data burst counter w_os: +1 on an AW handshake, -1 on a W handshake with w_last_i, net 0 when both occur; a W last arriving before its AW is allowed and is tracked as a signed lead of at most MaxOutstanding.
REQ-022 SHALL size wr_os and rd_os at $clog2(MaxOutstanding+1) bits; an increment at MaxOutstanding saturates and sets protocol_err_o.
REQ-023 SHALL, on any decrement at 0 (B with wr_os=0, R last with rd_os=0, or w_os lead exceeding MaxOutstanding), hold the counter and set protocol_err_o.
REQ-024 SHALL drive dma_busy_o = (wr_os!=0) | (rd_os!=0) | backend_busy_i, evaluated on the counter values that include the current cycle's updates, and registered.
REQ-025 SHALL keep protocol_err_o set until reset.

Reset
REQ-026 SHALL, while rst_i is high at a clock edge, clear all counters, all outputs and protocol_err_o to 0, including in the middle of a burst.
REQ-027 SHALL ignore handshakes during reset cycles; the first counted event is the one in the first cycle after rst_i falls.

Verification
REQ-028 SHALL cover: AW with len=3, size=6 accepted at cycle t -> at t+1 aw_done_o=1, aw_len_o=3, aw_size_o=6, dma_busy_o=1; B at t+10 -> dma_busy_o=0 at t+11.
REQ-029 SHALL cover: w_valid high with w_ready low for 4 cycles, then a handshake with strb=0x00FF (DataWidth=512) -> 4 w_stall_o pulses, then w_done_o=1 and num_bytes_written_o=8.
REQ-030 SHALL cover: an all-ones strobe at DataWidth=512 -> num_bytes_written_o=64.
REQ-031 SHALL cover: AR and R-last handshakes in the same cycle with rd_os=1 -> rd_os stays 1, ar_done_o=1, r_done_o=1, dma_busy_o=1.
REQ-032 SHALL cover: a B handshake with wr_os=0 -> protocol_err_o=1 next cycle and held; wr_os stays 0; rst_i clears it.
REQ-033 SHALL cover: 16 AWs with no B (MaxOutstanding=16), then a 17th AW -> wr_os=16 and protocol_err_o=1; rst_i asserted mid-burst -> all outputs 0 in the cycle after.
